// File: rtl/risc_v_rf_mp.sv
// Multi-read-port RISC-V integer register file with two write ports and a per-register busy scoreboard.
// Define RF_BYPASS_EN for write-first reads; leave it undefined for read-first reads.
module risc_v_rf_mp #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                wr1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic [NRP-1:0]      re,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                alloc,
  input  logic [AW-1:0]       alloc_addr
);

  localparam int NREGS = 2 ** AW;

  // There is no handshake: every write, alloc and read request is taken on the posedge it is
  // presented, with no valid/ready pair and no stall path.

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    busy;
  logic [NREGS-1:0]    busy_next;
  logic [NRP*XLEN-1:0] rdata_next;
  logic [NRP-1:0]      rbusy_next;

  logic wen0;
  logic wen1;

  assign wen0 = wr0 && (waddr0 != '0);
  assign wen1 = wr1 && (waddr1 != '0);

  // A write retires the pending producer; an alloc applied afterwards lets a new producer win.
  always_comb begin
    busy_next = busy;
    if (wen0) busy_next[waddr0] = 1'b0;
    if (wen1) busy_next[waddr1] = 1'b0;
    if (alloc && (alloc_addr != '0)) busy_next[alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      if (wen0) regs[waddr0] <= wdata0;
      if (wen1) regs[waddr1] <= wdata1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  always_comb begin : read_next
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    a          = '0;
    d          = '0;
    rdata_next = rdata;
    rbusy_next = rbusy;
    for (int i = 0; i < NRP; i++) begin
      a = raddr[i*AW +: AW];
      if (re[i]) begin
        if (a == '0) begin
          rdata_next[i*XLEN +: XLEN] = '0;
          rbusy_next[i]              = 1'b0;
        end else begin
`ifdef RF_BYPASS_EN
          d = regs[a];
          if (wen0 && (waddr0 == a)) d = wdata0;
          if (wen1 && (waddr1 == a)) d = wdata1;
          rdata_next[i*XLEN +: XLEN] = d;
          rbusy_next[i]              = busy_next[a];
`else
          d                          = regs[a];
          rdata_next[i*XLEN +: XLEN] = d;
          rbusy_next[i]              = busy[a];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      rbusy <= '0;
    end else begin
      rdata <= rdata_next;
      rbusy <= rbusy_next;
    end
  end

endmodule

// File: doc/risc_v_rf_mp.md
Name: risc_v_rf_mp

Overview:
- Parametrised successor to the team's 2R1W RISC-V register file: NRP synchronous read ports, two write ports (ALU and load/writeback), x0 hardwired to zero.
- Adds a per-register busy scoreboard: a producer allocates its destination, and the write to that register clears it.
- Sits between decode/issue (reads, alloc) and the writeback stage (writes) of the pipelined core.

Parameters:
- XLEN, 32, data width in bits.
- AW, 5, register address width; NREGS = 2**AW.
- NRP, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- wr0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  XLEN  write data, port 0.
- wr1  in  1  write enable, port 1.
- waddr1  in  AW  write address, port 1.
- wdata1  in  XLEN  write data, port 1.
- re  in  NRP  read enable, bit i = port i.
- raddr  in  NRP*AW  packed read addresses, port i at [i*AW +: AW].
- rdata  out  NRP*XLEN  packed registered read data.
- rbusy  out  NRP  registered busy flag of the register read on port i.
- alloc  in  1  mark alloc_addr busy (pending producer).
- alloc_addr  in  AW  register to mark busy.

Behaviour:
- Reset: reset low clears all NREGS registers, all busy bits, rdata and rbusy to 0 immediately, without waiting for clk. Release is synchronised by the integrator. Reset mid-operation discards in-flight writes and allocs.
- Writes: on posedge, wrN=1 stores wdataN into waddrN. Writes to address 0 are ignored.
- Same-address dual write: wr0 and wr1 to the same nonzero address in one cycle stores wdata1 (port 1 wins).
- Reads: 1-cycle latency. re[i]=1 at posedge loads rdata[i] and rbusy[i] for raddr[i].
  - re[i]=0 holds the previous rdata[i] and rbusy[i].
  - raddr[i]=0 always returns 0 and rbusy 0.
- Read-port independence: any number of ports may read the same address in the same cycle; all return identical values.
- Scoreboard:
  - alloc=1 at posedge sets busy[alloc_addr].
  - A write (either port) to address a clears busy[a].
  - Same-cycle alloc and write to the same address: busy ends set (the new producer wins).
  - alloc to address 0 is ignored.
  - A busy bit with no later write stays set until reset.
- Same-cycle read/write to the same address: governed by RF_BYPASS_EN (below).
- No handshake stall: the block always accepts every request in every cycle.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined (write-first): a read at the same posedge as a write to that nonzero address returns the newly written data, with port-1 priority on collision.
  - rbusy reflects the post-edge busy state: 0 after a clearing write, 1 if an alloc to that address is also present.
- Undefined (read-first): rdata and rbusy return the pre-edge contents and busy bit. The new value is visible on the next enabled read.

Test Plan:
- Async reset: write 32'h1234 to x15, pull reset low between clock edges → rdata, rbusy and all registers read 0 immediately; a subsequent read of x15 returns 0.
- Write/read with latency: wr0 x6=32'h12346, wr1 x7=32'h12347; next cycle re=2'b11, raddr x6/x7 → rdata 32'h12346/32'h12347 one edge later. Dropping re holds these values.
- x0 and dual-write collision:
  - wr0 x0=32'hFFFF → read x0 returns 0.
  - wr0 x9=32'hAAAA plus wr1 x9=32'hBBBB in the same cycle → read x9 returns 32'hBBBB.
- Same-cycle read/write: x2=32'hABCD, then write x2=32'h5555 while reading x2 on both ports → 32'h5555 with RF_BYPASS_EN defined, 32'hABCD without it; both ports are identical.
- Scoreboard:
  - alloc x8 → read x8 gives rbusy=1.
  - wr0 x8=32'h12348 → next read gives rbusy=0 and rdata 32'h12348.
  - alloc x8 with wr1 x8 in the same cycle → rbusy=1.
  - alloc x0 → rbusy 0.
- NRP=4 build: four ports read x6, x7, x0, x6 simultaneously → 32'h12346, 32'h12347, 0, 32'h12346.
